// File: rtl/hkspi_pkg.sv
// Shared state encodings and command-byte field positions for the
// housekeeping SPI responder.
package hkspi_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_CMD  = 3'd1;
  localparam state_t ST_ADDR = 3'd2;
  localparam state_t ST_DATA = 3'd3;
  localparam state_t ST_DONE = 3'd4;

  localparam int CMD_WR     = 7;
  localparam int CMD_RD     = 6;
  localparam int CMD_CNT_HI = 5;
  localparam int CMD_CNT_LO = 3;

  // Zero in this field means an unlimited byte stream.
  function automatic logic [2:0] cmd_count(input logic [7:0] cmd);
    return cmd[CMD_CNT_HI:CMD_CNT_LO];
  endfunction

endpackage

// File: rtl/hkspi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pad input, with registered
// one-clock rise/fall pulses (pin edge to pulse = STAGES+1 clocks).
module hkspi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clock,
  input  logic resetb,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              prev;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      sync <= {STAGES{RST_VAL}};
      prev <= RST_VAL;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], din};
      prev <= sync[STAGES-1];
      rise <= sync[STAGES-1] & ~prev;
      fall <= ~sync[STAGES-1] & prev;
    end
  end

  assign level = sync[STAGES-1];

endmodule

// File: rtl/hkspi_responder.sv
// Housekeeping SPI target: oversamples a mode-0 SPI port in the core clock
// domain and turns the command/address/data stream into register strobes.
//
// state   | meaning
// IDLE    | CSB high, waiting for CSB fall
// CMD     | shifting in the command byte
// ADDR    | shifting in the start address
// DATA    | data bytes, strobes at each byte end, address auto-increments
// DONE    | count exhausted or no-op; SCK ignored until CSB rises
module hkspi_responder
  import hkspi_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clock,
  input  logic              resetb,
  input  logic              sck,
  input  logic              csb,
  input  logic              sdi,
  output logic              sdo,
  output logic              sdo_oe,
  output logic [ADDR_W-1:0] reg_addr,
  output logic              reg_rd,
  input  logic [7:0]        reg_rdata,
  output logic              reg_we,
  output logic [7:0]        reg_wdata,
  output logic              busy
);

  state_t                 state;
  logic                   sck_rise, sck_fall, sck_level_unused;
  logic                   csb_level, csb_fall, csb_rise_unused;
  logic [SYNC_STAGES-1:0] sdi_sync;
  logic [2:0]             bit_cnt;
  logic [6:0]             rx_shift;
  logic [7:0]             rx_byte;
  logic [7:0]             tx_shift;
  logic                   cmd_wr, cmd_rd;
  logic                   cnt_limited;
  logic [2:0]             bytes_left;
  logic                   last_byte;
  logic                   incr_pend, rd_after_incr;

  hkspi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
    .clock  (clock),
    .resetb (resetb),
    .din    (sck),
    .level  (sck_level_unused),
    .rise   (sck_rise),
    .fall   (sck_fall)
  );

  hkspi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_csb_sync (
    .clock  (clock),
    .resetb (resetb),
    .din    (csb),
    .level  (csb_level),
    .rise   (csb_rise_unused),
    .fall   (csb_fall)
  );

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) sdi_sync <= '0;
    else         sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], sdi};
  end

  assign rx_byte   = {rx_shift, sdi_sync[SYNC_STAGES-1]};
  assign last_byte = cnt_limited && (bytes_left == 3'd1);
  assign busy      = ~csb_level;
  assign sdo       = tx_shift[7];

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state         <= ST_IDLE;
      bit_cnt       <= '0;
      rx_shift      <= '0;
      tx_shift      <= '0;
      sdo_oe        <= 1'b0;
      reg_addr      <= '0;
      reg_rd        <= 1'b0;
      reg_we        <= 1'b0;
      reg_wdata     <= '0;
      cmd_wr        <= 1'b0;
      cmd_rd        <= 1'b0;
      cnt_limited   <= 1'b0;
      bytes_left    <= '0;
      incr_pend     <= 1'b0;
      rd_after_incr <= 1'b0;
    end else begin
      reg_rd <= 1'b0;
      reg_we <= 1'b0;
      // Synchronized CSB level has priority, so an SCK rise landing with a
      // CSB rise can never produce a strobe.
      if (csb_level) begin
        state     <= ST_IDLE;
        bit_cnt   <= '0;
        tx_shift  <= '0;
        sdo_oe    <= 1'b0;
        incr_pend <= 1'b0;
      end else begin
        if (reg_rd && state == ST_DATA) begin
          tx_shift <= reg_rdata;
          sdo_oe   <= 1'b1;
        end
        // Writes hold the address for their strobe; the increment follows.
        if (incr_pend) begin
          incr_pend <= 1'b0;
          reg_addr  <= reg_addr + ADDR_W'(1);
          reg_rd    <= rd_after_incr;
        end
        case (state)
          ST_IDLE: begin
            if (csb_fall) begin
              state   <= ST_CMD;
              bit_cnt <= '0;
            end
          end
          ST_CMD: begin
            if (sck_rise) begin
              bit_cnt  <= bit_cnt + 3'd1;
              rx_shift <= rx_byte[6:0];
              if (bit_cnt == 3'd7) begin
                cmd_wr      <= rx_byte[CMD_WR];
                cmd_rd      <= rx_byte[CMD_RD];
                bytes_left  <= cmd_count(rx_byte);
                cnt_limited <= |cmd_count(rx_byte);
                state       <= (rx_byte[CMD_WR] || rx_byte[CMD_RD]) ? ST_ADDR : ST_DONE;
              end
            end
          end
          ST_ADDR: begin
            if (sck_rise) begin
              bit_cnt  <= bit_cnt + 3'd1;
              rx_shift <= rx_byte[6:0];
              if (bit_cnt == 3'd7) begin
                reg_addr <= ADDR_W'(rx_byte);
                reg_rd   <= cmd_rd;
                state    <= ST_DATA;
              end
            end
          end
          ST_DATA: begin
            if (sck_rise) begin
              bit_cnt  <= bit_cnt + 3'd1;
              rx_shift <= rx_byte[6:0];
              if (bit_cnt == 3'd7) begin
                if (cnt_limited) bytes_left <= bytes_left - 3'd1;
                if (last_byte) begin
                  state    <= ST_DONE;
                  tx_shift <= '0;
                  sdo_oe   <= 1'b0;
                end
                if (cmd_wr) begin
                  reg_we        <= 1'b1;
                  reg_wdata     <= rx_byte;
                  incr_pend     <= 1'b1;
                  rd_after_incr <= cmd_rd && !last_byte;
                end else begin
                  reg_addr <= reg_addr + ADDR_W'(1);
                  reg_rd   <= cmd_rd && !last_byte;
                end
              end
            end else if (sck_fall && bit_cnt != 3'd0) begin
              tx_shift <= {tx_shift[6:0], 1'b0};
            end
          end
          ST_DONE: begin
            tx_shift <= '0;
            sdo_oe   <= 1'b0;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hkspi_responder.sv
// Scoreboard bench for hkspi_responder: directed SPI transactions push
// expected strobes and SDO bytes; independent monitors pop and compare.
module tb_hkspi_responder;

  localparam int HALF = 80;

  typedef struct packed {
    logic       is_we;
    logic [7:0] addr;
    logic [7:0] data;
  } strb_t;

  logic       clock, resetb, sck, csb, sdi;
  logic       sdo, sdo_oe, reg_rd, reg_we, busy;
  logic [7:0] reg_addr, reg_rdata, reg_wdata;
  logic [7:0] mem [0:255];

  int checks   = 0;
  int failures = 0;

  strb_t      strb_q[$];
  logic [8:0] miso_q[$];
  strb_t      se;
  logic [8:0] me;
  int         mbit;
  logic [7:0] mbyte;
  logic       oe_any, oe_all;

  hkspi_responder #(.ADDR_W(8), .SYNC_STAGES(2)) dut (
    .clock     (clock),
    .resetb    (resetb),
    .sck       (sck),
    .csb       (csb),
    .sdi       (sdi),
    .sdo       (sdo),
    .sdo_oe    (sdo_oe),
    .reg_addr  (reg_addr),
    .reg_rd    (reg_rd),
    .reg_rdata (reg_rdata),
    .reg_we    (reg_we),
    .reg_wdata (reg_wdata),
    .busy      (busy)
  );

  assign reg_rdata = mem[reg_addr];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired before end of test sequence");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic exp_we(input logic [7:0] a, input logic [7:0] d);
    strb_q.push_back('{is_we: 1'b1, addr: a, data: d});
  endtask

  task automatic exp_rd(input logic [7:0] a);
    strb_q.push_back('{is_we: 1'b0, addr: a, data: 8'h00});
  endtask

  task automatic spi_byte(input logic [7:0] b, input logic [7:0] miso, input logic oe);
    miso_q.push_back({oe, miso});
    for (int i = 7; i >= 0; i--) begin
      sdi = b[i];
      #HALF sck = 1'b1;
      #HALF sck = 1'b0;
    end
  endtask

  task automatic spi_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      sdi = b[i];
      #HALF sck = 1'b1;
      #HALF sck = 1'b0;
    end
  endtask

  task automatic csb_lo();
    csb = 1'b0;
    #HALF;
    chk("busy_active", busy, 1);
  endtask

  task automatic csb_hi();
    #HALF csb = 1'b1;
    sdi = 1'b0;
    #(4*HALF);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_sdo"},       sdo,       0);
    chk({tag, "_sdo_oe"},    sdo_oe,    0);
    chk({tag, "_reg_addr"},  reg_addr,  0);
    chk({tag, "_reg_rd"},    reg_rd,    0);
    chk({tag, "_reg_we"},    reg_we,    0);
    chk({tag, "_reg_wdata"}, reg_wdata, 0);
    chk({tag, "_busy"},      busy,      0);
  endtask

  // Strobe monitor
  always @(negedge clock) begin
    if (resetb === 1'b1 && (reg_we || reg_rd)) begin
      if (strb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_strobe actual we=%0b rd=%0b addr=%h wdata=%h required=none",
                 reg_we, reg_rd, reg_addr, reg_wdata);
      end else begin
        se = strb_q.pop_front();
        chk("strobe", {15'd0, reg_we, reg_addr, (reg_we ? reg_wdata : 8'h00)},
                      {15'd0, se.is_we, se.addr, se.data});
      end
    end
  end

  // SDO byte monitor: host samples on SCK rise
  always @(posedge sck or posedge csb) begin
    if (csb) begin
      mbit = 0;
    end else begin
      if (mbit == 0) begin
        oe_any = 1'b0;
        oe_all = 1'b1;
      end
      mbyte  = {mbyte[6:0], sdo};
      oe_any = oe_any | sdo_oe;
      oe_all = oe_all & sdo_oe;
      mbit++;
      if (mbit == 8) begin
        mbit = 0;
        if (miso_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_sdo_byte actual=%h required=none", mbyte);
        end else begin
          me = miso_q.pop_front();
          chk("sdo_byte", {22'd0, oe_any, oe_all, mbyte}, {22'd0, me[8], me[8], me[7:0]});
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
    mem[0] = 8'h00; mem[1] = 8'h04; mem[2] = 8'h56; mem[3] = 8'h11;
    resetb = 1'b0; csb = 1'b1; sck = 1'b0; sdi = 1'b0;
    mbit = 0; mbyte = '0; oe_any = 1'b0; oe_all = 1'b1;
    #23;
    chk_reset_outputs("reset");
    @(negedge clock) resetb = 1'b1;
    repeat (5) @(negedge clock);

    // Stream read from address 0
    exp_rd(8'h00); exp_rd(8'h01); exp_rd(8'h02); exp_rd(8'h03); exp_rd(8'h04);
    csb_lo();
    spi_byte(8'h40, 8'h00, 1'b0);
    spi_byte(8'h00, 8'h00, 1'b0);
    spi_byte(8'h00, 8'h00, 1'b1);
    spi_byte(8'h00, 8'h04, 1'b1);
    spi_byte(8'h00, 8'h56, 1'b1);
    spi_byte(8'h00, 8'h11, 1'b1);
    chk("oe_before_csb_rise", sdo_oe, 1);
    #HALF csb = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("oe_after_csb_rise", sdo_oe, 0);
    chk("busy_after_csb_rise", busy, 0);
    #(4*HALF);

    // Single writes
    exp_we(8'h0B, 8'h01);
    csb_lo();
    spi_byte(8'h80, 8'h00, 1'b0);
    spi_byte(8'h0B, 8'h00, 1'b0);
    spi_byte(8'h01, 8'h00, 1'b0);
    csb_hi();
    exp_we(8'h0B, 8'h00);
    csb_lo();
    spi_byte(8'h80, 8'h00, 1'b0);
    spi_byte(8'h0B, 8'h00, 1'b0);
    spi_byte(8'h00, 8'h00, 1'b0);
    csb_hi();

    // Count-limited read: one byte then DONE
    exp_rd(8'h03);
    csb_lo();
    spi_byte(8'h48, 8'h00, 1'b0);
    spi_byte(8'h03, 8'h00, 1'b0);
    spi_byte(8'h00, 8'h11, 1'b1);
    spi_byte(8'h00, 8'h00, 1'b0);
    csb_hi();

    // Address wrap on write stream
    exp_we(8'hFF, 8'hAA); exp_we(8'h00, 8'h55);
    csb_lo();
    spi_byte(8'h80, 8'h00, 1'b0);
    spi_byte(8'hFF, 8'h00, 1'b0);
    spi_byte(8'hAA, 8'h00, 1'b0);
    spi_byte(8'h55, 8'h00, 1'b0);
    csb_hi();

    // Abort mid-byte, then a clean read
    csb_lo();
    spi_byte(8'h80, 8'h00, 1'b0);
    spi_byte(8'h10, 8'h00, 1'b0);
    spi_bits(8'hC3, 5);
    csb_hi();
    exp_rd(8'h03); exp_rd(8'h04);
    csb_lo();
    spi_byte(8'h40, 8'h00, 1'b0);
    spi_byte(8'h03, 8'h00, 1'b0);
    spi_byte(8'h00, 8'h11, 1'b1);
    csb_hi();

    // No-op command
    csb_lo();
    spi_byte(8'h00, 8'h00, 1'b0);
    spi_byte(8'h12, 8'h00, 1'b0);
    csb_hi();

    // Read-write, count 1
    exp_rd(8'h02); exp_we(8'h02, 8'h99);
    csb_lo();
    spi_byte(8'hC8, 8'h00, 1'b0);
    spi_byte(8'h02, 8'h00, 1'b0);
    spi_byte(8'h99, 8'h56, 1'b1);
    csb_hi();

    // Reset in the middle of an address byte
    csb_lo();
    spi_byte(8'h80, 8'h00, 1'b0);
    spi_bits(8'h20, 4);
    resetb = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    csb = 1'b1; sck = 1'b0; sdi = 1'b0;
    #50;
    @(negedge clock) resetb = 1'b1;
    repeat (5) @(negedge clock);
    exp_we(8'h21, 8'h5A);
    csb_lo();
    spi_byte(8'h80, 8'h00, 1'b0);
    spi_byte(8'h21, 8'h00, 1'b0);
    spi_byte(8'h5A, 8'h00, 1'b0);
    csb_hi();

    repeat (20) @(negedge clock);
    chk("strobe_queue_drained", strb_q.size(), 0);
    chk("sdo_queue_drained", miso_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
